// File: rtl/prog_loader.sv
// prog_loader: assembles a length-prefixed byte stream into 32-bit words
// and writes them to consecutive word addresses from BASE_ADDR.
// Ports: clk, reset (async, active-high); start; byte_valid/byte_data/
// byte_ready stream input; mem_we/mem_a/mem_wd memory write port;
// busy, cpu_hold, done, err, word_count status.
// Optional: PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_BYTES,
    S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t      r_state;
  logic [7:0]  r_n;
  logic [7:0]  r_widx;
  logic [1:0]  r_bidx;
  logic [23:0] r_acc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  state_t w_nxt;
  logic   w_acc;
  logic   w_over;
  logic   w_last;

  assign w_acc  = byte_valid & byte_ready;
  assign w_over = 32'(byte_data) > MAX_WORDS;
  assign w_last = (r_widx + 8'd1) == r_n;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_acc) begin
          if (byte_data == 8'd0) w_nxt = S_END;
          else if (w_over)       w_nxt = S_DONE;
          else                   w_nxt = S_BYTES;
        end
      end
      S_BYTES: begin
        if (w_acc && r_bidx == 2'd3) w_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_nxt = w_last ? S_END : S_BYTES;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_acc) w_nxt = S_DONE;
      end
`endif
      default: w_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_n        <= 8'd0;
      r_widx     <= 8'd0;
      r_bidx     <= 2'd0;
      r_acc      <= 24'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= BASE_ADDR;
      mem_wd     <= 32'd0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= 8'd0;
    end else begin
      r_state    <= w_nxt;
      byte_ready <= (w_nxt == S_LEN) || (w_nxt == S_BYTES)
`ifdef PROG_LOADER_CHECKSUM_EN
                    || (w_nxt == S_CHK)
`endif
                    ;
      busy       <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      cpu_hold   <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      done       <= (w_nxt == S_DONE);
      mem_we     <= (w_nxt == S_WRITE);
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            word_count <= 8'd0;
            err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
          end
        end
        S_LEN: begin
          if (w_acc) begin
            r_n    <= byte_data;
            r_widx <= 8'd0;
            r_bidx <= 2'd0;
            if (w_over) err <= 1'b1;
          end
        end
        S_BYTES: begin
          if (w_acc) begin
            r_acc  <= {r_acc[15:0], byte_data};
            r_bidx <= r_bidx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            // Present address/data together with the write pulse.
            if (r_bidx == 2'd3) begin
              mem_a  <= BASE_ADDR + {22'd0, r_widx, 2'b00};
              mem_wd <= {r_acc, byte_data};
            end
          end
        end
        S_WRITE: begin
          word_count <= word_count + 8'd1;
          r_widx     <= r_widx + 8'd1;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_acc) err <= (byte_data != r_csum);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed stream loads checked against a
// word-list reference model of the expected memory writes and status.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXW = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [7:0]  word_count;

  always #5 clk = ~clk;

  prog_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .mem_we(mem_we),
    .mem_a(mem_a),
    .mem_wd(mem_wd),
    .busy(busy),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err),
    .word_count(word_count)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] cap_a[$];
  logic [31:0] cap_d[$];

  always @(negedge clk) begin
    if (mem_we) begin
      cap_a.push_back(mem_a);
      cap_d.push_back(mem_wd);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Model: a legal length yields writes of the given words at
  // BASE+4*i and word_count=n; an oversize length yields nothing.
  task automatic run_load(input logic [7:0] n, input logic [31:0] wq[$],
                          input int gap, input bit bad, input bit poke);
    logic [7:0] x;
    logic [7:0] b;
    bit         ok;
    bit         exp_err;
    int         t;
    int         m;
    x = 8'd0;
    t = 0;
    cap_a.delete();
    cap_d.delete();
    ok = (int'(n) <= MAXW);
    pulse_start();
    chk("hold_start", {30'd0, busy, cpu_hold}, 32'd3);
    chk("wc_clr", 32'(word_count), 32'd0);
    send_byte(n, gap);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int j = 0; j < 4; j++) begin
          b = wq[i][31-8*j -: 8];
          x = x ^ b;
          send_byte(b, gap);
          if (poke && i == 0 && j == 1) pulse_start();
        end
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (ok) send_byte(x ^ {7'd0, bad}, gap);
    exp_err = !ok || bad;
`else
    exp_err = !ok;
`endif
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(done), 32'd1);
    chk("hold_end", {30'd0, busy, cpu_hold}, 32'd0);
    chk("err", 32'(err), 32'(exp_err));
    chk("wc", 32'(word_count), ok ? 32'(n) : 32'd0);
    m = ok ? int'(n) : 0;
    chk("nwr", 32'(cap_a.size()), 32'(m));
    for (int i = 0; i < m && i < cap_a.size(); i++) begin
      chk("addr", cap_a[i], BASE + 32'(4 * i));
      chk("data", cap_d[i], wq[i]);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] e[$];
    int          n;
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_a", mem_a, BASE);
    chk("rst_flags", {28'd0, busy, cpu_hold, done, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    q = '{32'h12345678, 32'hDEADBEEF};
    run_load(8'd2, q, 0, 1'b0, 1'b0);
    run_load(8'd2, q, 3, 1'b0, 1'b0);
    run_load(8'hC8, e, 0, 1'b0, 1'b0);
    run_load(8'd0, e, 0, 1'b0, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    q = '{32'h01020304};
    run_load(8'd1, q, 0, 1'b0, 1'b0);
    run_load(8'd1, q, 0, 1'b1, 1'b0);
    run_load(8'd0, e, 0, 1'b1, 1'b0);
`endif
    q = '{32'hCAFEF00D, 32'h0BADBEEF};
    run_load(8'd2, q, 1, 1'b0, 1'b1);

    // Abort mid-word: nothing may be written and all outputs clear.
    cap_a.delete();
    cap_d.delete();
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_ready", 32'(byte_ready), 32'd0);
    chk("mid_we", 32'(mem_we), 32'd0);
    chk("mid_a", mem_a, BASE);
    chk("mid_wd", mem_wd, 32'd0);
    chk("mid_flags", {28'd0, busy, cpu_hold, done, err}, 32'd0);
    chk("mid_wc", 32'(word_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_nwr", 32'(cap_a.size()), 32'd0);
    q = '{32'h55AA33CC};
    run_load(8'd1, q, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      n = (k == 5) ? int'($urandom_range(129, 255))
                   : int'($urandom_range(0, 8));
      q.delete();
      for (int i = 0; i < n && i < 8; i++) q.push_back($urandom);
      run_load(8'(n), q, int'($urandom_range(0, 2)),
               1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the writer side of the instruction/data memory word interface (we, a, wd) that the CPU otherwise only reads.
- Assembles an incoming serial byte stream into 32-bit words and writes them to consecutive word-aligned addresses starting at BASE_ADDR.
- Holds the CPU off (cpu_hold) while loading and flags completion or error.
- Sits between a host byte source (UART receiver / testbench) and the memory write port, before the processor comes out of hold.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word-aligned.
- MAX_WORDS, 128: capacity in words; legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  memory write enable, one-cycle pulse per word
- mem_a  output  32  memory byte address, word-aligned
- mem_wd  output  32  memory write data
- busy  output  1  load in progress (states LEN..CHK)
- cpu_hold  output  1  equals busy; keeps the processor stalled
- done  output  1  level, high in DONE
- err  output  1  level, valid while done=1
- word_count  output  8  words written in the current or last load

Behaviour:
- Reset (async, active-high): state=IDLE; byte_ready=0, mem_we=0, mem_a=BASE_ADDR, mem_wd=0, busy=0, cpu_hold=0, done=0, err=0, word_count=0; internal byte index=0, word index=0, accumulator=0. Memory contents already written are not affected.
- Handshake: a byte transfers on a rising edge where byte_valid&byte_ready=1. byte_data must stay stable while valid and not ready.
- Stream format: length byte N, then 4*N data bytes, MSB first per word (byte0 -> wd[31:24]). With CHECKSUM_EN, one trailing checksum byte follows.
- States:
  - IDLE: byte_ready=0. start=1 -> LEN; clears word_count, err, and the checksum accumulator.
  - LEN: byte_ready=1. On accept: if N=0 -> CHK when CHECKSUM_EN is defined, else DONE. If N>MAX_WORDS -> DONE with err=1 and no writes. Otherwise latch N -> BYTES.
  - BYTES: byte_ready=1. Each accepted byte shifts into the accumulator (acc <= {acc[23:0],byte}). The 4th accepted byte -> WRITE.
  - WRITE (1 cycle): byte_ready=0, mem_we=1, mem_a=BASE_ADDR+4*word_index, mem_wd=assembled word; word_count increments on this edge. If word_index+1=N -> CHK (CHECKSUM_EN) or DONE; else -> BYTES.
  - CHK: byte_ready=1. On accept: err <= (byte != running XOR) -> DONE.
  - DONE: done=1, busy=0, byte_ready=0. start=1 -> LEN (restart).
- Latency: mem_we asserts the cycle after the 4th byte of a word is accepted. Minimum 5 cycles per word at full byte rate.
- mem_we is 0 in every state except WRITE. mem_a and mem_wd hold their last values outside WRITE.
- start is ignored while busy. byte_valid is ignored in IDLE, DONE and WRITE (byte_ready=0).
- Address arithmetic: 32-bit, wrap-around ignored; BASE_ADDR+4*(MAX_WORDS-1) must fit in memory.
- Reset mid-load: immediate abort to IDLE. A partial word is never written.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: the stream carries a trailing checksum byte equal to the XOR of all 4*N data bytes (0x00 when N=0). CHK state is present. err=1 on mismatch. Words are still written before the check.
- Undefined: there is no CHK state and no checksum byte. err is set only for N>MAX_WORDS.

Test Plan:
- Reset mid-stream: reset after 2 data bytes -> all outputs return to reset values within the same cycle (async); mem_we never asserted; next start loads cleanly.
- Two words: start, bytes 02, 12 34 56 78, DE AD BE EF, full rate, BASE_ADDR=0 -> mem_we pulses with (a=0x0, wd=0x12345678) then (a=0x4, wd=0xDEADBEEF); done=1, err=0, word_count=2; cpu_hold high from the cycle after start until DONE.
- Backpressure/gaps: same stream with byte_valid deasserted 3 cycles between bytes -> identical writes; no byte lost or duplicated.
- Oversize: N=0xC8 with MAX_WORDS=128 -> no mem_we, DONE with err=1, word_count=0. Zero-length: N=0 -> DONE, err=0 (checksum build: send 00 -> err=0).
- Checksum (PROG_LOADER_CHECKSUM_EN): N=1, 01 02 03 04, checksum 04 -> err=0; checksum 05 -> err=1 with word 0x01020304 still written at BASE_ADDR.
- Restart and ignore: start pulsed during BYTES is ignored; start in DONE begins a new load with word_count cleared to 0.
